mmio_bus_master: RTL
====================

MMIO_BUS_MASTER -- requirements
Module: mmio_bus_master

Interface
REQ-001 SHALL have parameter READ_WAIT, default 0, range 0..15: extra cycles read enable is held before read data is sampled.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  pipeline request present.
REQ-005 SHALL have port req_ready  output  1  master accepts request this cycle.
REQ-006 SHALL have port req_write  input  1  1=store, 0=load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data.
REQ-009 SHALL have port resp_valid  output  1  response present.
REQ-010 SHALL have port resp_ready  input  1  pipeline consumes response.
REQ-011 SHALL have port resp_rdata  output  32  load data; 0 for stores.
REQ-012 SHALL have port resp_err  output  1  request rejected, no bus access.
REQ-013 SHALL have port address  output  32  peripheral bus address.
REQ-014 SHALL have port write_data  output  32  peripheral bus store data.
REQ-015 SHALL have port write_enable  output  1  peripheral write strobe.
REQ-016 SHALL have port read_enable  output  1  peripheral read strobe.
REQ-017 SHALL have port read_data  input  32  peripheral combinational read data.

Function
REQ-018 SHALL implement states IDLE, ACCESS, RESP; request accepted only when req_valid && req_ready.
REQ-019 SHALL drive req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-020 SHALL on acceptance register req_addr/req_wdata/req_write onto address/write_data and enter ACCESS next cycle.
REQ-021 SHALL for a store assert write_enable for exactly one ACCESS cycle, then enter RESP with resp_rdata=0.
REQ-022 SHALL for a load assert read_enable for READ_WAIT+1 consecutive ACCESS cycles (4-bit down counter), capture read_data at the rising edge ending the last such cycle into resp_rdata, then enter RESP.
REQ-023 SHALL never assert write_enable and read_enable together; both 0 outside ACCESS.
REQ-024 SHALL hold address and write_data stable throughout ACCESS; they retain last value outside ACCESS.
REQ-025 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready=1; then return to IDLE next cycle.
REQ-026 SHALL give latency accept-edge to resp_valid of 2 cycles for stores and 2+READ_WAIT for loads.
REQ-027 SHALL ignore req_valid and all req_* inputs outside IDLE; no request buffering, one outstanding transaction.
REQ-028 SHALL leave resp_valid low at least one cycle between consecutive responses (RESP->IDLE->ACCESS).

Reset
REQ-029 SHALL on rst_n=0 immediately force state IDLE, counter 0, req_ready=0 while asserted, resp_valid=0, resp_rdata=0, resp_err=0, address=0, write_data=0, write_enable=0, read_enable=0.
REQ-030 SHALL abort any in-flight ACCESS or RESP on reset with no further strobe; req_ready=1 first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with MMIO_ALIGN_CHECK_EN defined, treat accepted requests with req_addr[1:0]!=0 as errors: skip ACCESS, no strobe, enter RESP next cycle with resp_err=1, resp_rdata=0.
REQ-032 SHALL, without MMIO_ALIGN_CHECK_EN, forward all addresses unchanged and tie resp_err to 0.

Verification
REQ-033 SHALL test store: addr 0xA0000100, wdata 0x12345678 -> write_enable high exactly 1 cycle with those values, resp_valid 2 cycles after accept, resp_rdata 0.
REQ-034 SHALL test load READ_WAIT=0: addr 0xA0000000, responder returns 0xDEADBEEF -> read_enable 1 cycle, resp_rdata 0xDEADBEEF.
REQ-035 SHALL test READ_WAIT=2: read_enable high 3 cycles, read_data changed 0x1->0x2->0x3 -> resp_rdata 0x3, resp_valid 4 cycles after accept.
REQ-036 SHALL test backpressure: resp_ready low 3 cycles -> resp_valid/resp_rdata stable, req_ready 0, new req_valid ignored.
REQ-037 SHALL test macro defined, addr 0xA0000102 -> no strobe, resp_err=1 next cycle; macro undefined -> normal access at 0xA0000102.
REQ-038 SHALL test rst_n low mid-ACCESS of a 3-cycle load -> read_enable drops asynchronously, all outputs 0, req_ready=1 after release.

Source files
------------

// File: rtl/mmio_bus_master.sv
// Single-outstanding MMIO master: pipeline request/response handshake onto a strobe-based peripheral bus.
// Define MMIO_ALIGN_CHECK_EN to reject word-misaligned requests with resp_err instead of accessing the bus.
module mmio_bus_master #(
    parameter int READ_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        write_enable,
    output logic        read_enable,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        write_r;
    logic        write_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_s;
    logic        err_s;
    logic        we_s;
    logic        re_s;
    logic        misaligned_s;

`ifdef MMIO_ALIGN_CHECK_EN
    assign misaligned_s = (req_addr[1:0] != 2'b00);
`else
    assign misaligned_s = 1'b0;
`endif

    // Ready is forced low while reset is held so nothing is accepted during reset
    assign req_ready  = rst_n & (state_r == IDLE);
    assign resp_valid = (state_r == RESP);

    // Next-state and next-output decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        write_s = write_r;
        addr_s  = address;
        wdata_s = write_data;
        rdata_s = resp_rdata;
        err_s   = resp_err;
        we_s    = 1'b0;
        re_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    addr_s  = req_addr;
                    wdata_s = req_wdata;
                    write_s = req_write;
                    cnt_s   = 4'(READ_WAIT);
                    rdata_s = 32'h0000_0000;
                    if (misaligned_s) begin
                        state_s = RESP;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ACCESS;
                        err_s   = 1'b0;
                        we_s    = req_write;
                        re_s    = ~req_write;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // Strobes for the ACCESS cycle are registered on entry; the last read cycle samples read_data
                if (write_r) begin
                    state_s = RESP;
                    rdata_s = 32'h0000_0000;
                end else if (cnt_r == 4'd0) begin
                    state_s = RESP;
                    rdata_s = read_data;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                    re_s  = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered bus/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            write_r      <= 1'b0;
            address      <= 32'h0000_0000;
            write_data   <= 32'h0000_0000;
            resp_rdata   <= 32'h0000_0000;
            resp_err     <= 1'b0;
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            write_r      <= write_s;
            address      <= addr_s;
            write_data   <= wdata_s;
            resp_rdata   <= rdata_s;
            resp_err     <= err_s;
            write_enable <= we_s;
            read_enable  <= re_s;
        end
    end

endmodule
